// File: rtl/traffic_pkg.sv
// Shared definitions for the N-way traffic light controller.
//   light_t : per-way light code driven on o_light (R=00, G=01, Y=10)
//   state_t : main phase FSM states
//   hold_t  : manual/police hold sub-FSM states
package traffic_pkg;

  typedef enum logic [1:0] {
    L_R = 2'b00,
    L_G = 2'b01,
    L_Y = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  typedef enum logic {
    H_NORMAL = 1'b0,
    H_HOLD   = 1'b1
  } hold_t;

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of i_req searching from i_cur+1 upward with wrap,
// never selecting i_cur itself.
//   i_req   : request vector, bit k = way k
//   i_cur   : index of the current owner (excluded from the search)
//   o_valid : a request other than i_cur exists
//   o_idx   : index of the chosen way (0 when o_valid=0)
module traffic_rr_pick
  import traffic_pkg::*;
#(
  parameter int N_WAY = 4
) (
  input  logic [N_WAY-1:0]         i_req,
  input  logic [$clog2(N_WAY)-1:0] i_cur,
  output logic                     o_valid,
  output logic [$clog2(N_WAY)-1:0] o_idx
);

  localparam int PW = $clog2(N_WAY);

  // Walk offsets from farthest to nearest so the nearest hit overwrites
  // any farther one, leaving the round-robin winner.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int unsigned off = N_WAY - 1; off >= 1; off--) begin
      idx = (32'(i_cur) + off) % N_WAY;
      if (i_req[idx[PW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-way traffic light controller with demand-driven green, min/max green,
// yellow, optional all-red clearance and a manual hold mode.
//   i_clk    : clock, rising edge
//   i_rstn   : asynchronous active-low reset
//   i_traff  : per-way vehicle-present flags
//   i_mode_p : enter hold (blocks green exit)
//   i_mode_r : release hold
//   o_light  : 2 bits per way, way k in [2k+1:2k]
//   o_phase  : way currently owning green/yellow
//   o_hold   : hold mode active
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int N_WAY    = 4,
  parameter int CNT_W    = 8,
  parameter int T_GMIN   = 5,
  parameter int T_GMAX   = 20,
  parameter int T_YEL    = 3,
  parameter int T_ALLRED = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [N_WAY-1:0]         i_traff,
  input  logic                     i_mode_p,
  input  logic                     i_mode_r,
  output logic [2*N_WAY-1:0]       o_light,
  output logic [$clog2(N_WAY)-1:0] o_phase,
  output logic                     o_hold
);

  localparam int PW = $clog2(N_WAY);

  // Timer value seen in the last cycle of each interval.
  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GMIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GMAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'((T_ALLRED > 0) ? T_ALLRED - 1 : 0);

  state_t           state, state_nxt;
  hold_t            hold, hold_nxt;
  logic [CNT_W-1:0] timer;
  logic [PW-1:0]    phase, nxt_phase;
  logic             cand_valid;
  logic [PW-1:0]    cand_idx;
  logic             green_exit;

  traffic_rr_pick #(.N_WAY(N_WAY)) u_pick (
    .i_req   (i_traff),
    .i_cur   (phase),
    .o_valid (cand_valid),
    .o_idx   (cand_idx)
  );

  always_comb begin
    hold_nxt = hold;
    if (hold == H_NORMAL) begin
      if (i_mode_p) hold_nxt = H_HOLD;
    end else begin
      if (i_mode_r) hold_nxt = H_NORMAL;
    end
  end

  always_comb begin
    green_exit = (hold == H_NORMAL) && cand_valid && (timer >= GMIN_LAST) &&
                 (!i_traff[phase] || (timer >= GMAX_LAST));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_GREEN:  if (green_exit) state_nxt = ST_YELLOW;
      ST_YELLOW: if (timer == YEL_LAST)
                   state_nxt = (T_ALLRED > 0) ? ST_ALLRED : ST_GREEN;
      ST_ALLRED: if (timer == AR_LAST) state_nxt = ST_GREEN;
      default:   state_nxt = ST_GREEN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= ST_GREEN;
      hold      <= H_NORMAL;
      timer     <= '0;
      phase     <= '0;
      nxt_phase <= '0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      if (state_nxt != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
      if (state == ST_GREEN && state_nxt == ST_YELLOW)
        nxt_phase <= cand_idx;
      if (state != ST_GREEN && state_nxt == ST_GREEN)
        phase <= nxt_phase;
    end
  end

  always_comb begin
    o_light = '0;
    for (int unsigned k = 0; k < N_WAY; k++) begin
      if (state != ST_ALLRED && phase == PW'(k))
        o_light[2*k +: 2] = (state == ST_YELLOW) ? L_Y : L_G;
    end
    o_phase = phase;
    o_hold  = (hold == H_HOLD);
  end

endmodule

// File: doc/traffic_ctrl_n.md
TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

Interface
REQ-001 Parameter N_WAY, default 4, number of approaches; legal range 2..8.
REQ-002 Parameter CNT_W, default 8, phase-timer width.
REQ-003 Parameter T_GMIN, default 5, minimum green cycles; legal range 1..2^CNT_W-1.
REQ-004 Parameter T_GMAX, default 20, maximum green cycles when contested; must be >= T_GMIN.
REQ-005 Parameter T_YEL, default 3, yellow cycles; legal range >= 1.
REQ-006 Parameter T_ALLRED, default 1, all-red clearance cycles; 0 means no all-red interval.
REQ-007 i_clk  input  1  clock, rising edge.
REQ-008 i_rstn  input  1  reset, asynchronous, active-low.
REQ-009 i_traff  input  N_WAY  per-approach vehicle-present flag, bit k = way k.
REQ-010 i_mode_p  input  1  hold (manual/police) request.
REQ-011 i_mode_r  input  1  hold release.
REQ-012 o_light  output  2*N_WAY  light code for way k in bits [2k+1:2k]; R=00, G=01, Y=10; 11 never driven.
REQ-013 o_phase  output  clog2(N_WAY)  index of the way currently owning green/yellow.
REQ-014 o_hold  output  1  hold mode active.

Function
REQ-015 The main FSM SHALL have states GREEN, YELLOW, ALLRED; outputs are Moore, decoded from registered state, phase and hold.
REQ-016 In GREEN/YELLOW, way o_phase SHALL show G/Y and all other ways R; in ALLRED all ways SHALL show R.
REQ-017 The timer SHALL clear to 0 on every state change and otherwise increment by 1 per cycle, saturating at 2^CNT_W-1.
REQ-018 A candidate SHALL be the first way with i_traff set, searching round-robin from o_phase+1 with wrap from N_WAY-1 to 0, excluding o_phase.
REQ-019 GREEN->YELLOW SHALL occur when o_hold=0, a candidate exists, timer >= T_GMIN-1, and (i_traff[o_phase]=0 or timer >= T_GMAX-1).
REQ-020 With no candidate, GREEN SHALL persist indefinitely (rest in green).
REQ-021 The candidate SHALL be latched into a next-phase register on the GREEN->YELLOW edge; later i_traff changes do not alter it.
REQ-022 YELLOW SHALL last exactly T_YEL cycles, then go to ALLRED (T_ALLRED>0) or GREEN (T_ALLRED=0).
REQ-023 ALLRED SHALL last exactly T_ALLRED cycles, then GREEN.
REQ-024 o_phase SHALL load the latched next-phase on entry to GREEN, so it changes in the same cycle the new green appears.
REQ-025 Hold sub-FSM NORMAL/HOLD: NORMAL->HOLD on i_mode_p=1; HOLD->NORMAL on i_mode_r=1; with both high, NORMAL goes to HOLD and HOLD goes to NORMAL.
REQ-026 Hold SHALL only block GREEN exit; YELLOW and ALLRED entered before hold SHALL complete normally.
REQ-027 After release, GREEN exit SHALL be re-evaluated per REQ-019 using the current timer value, with no restart of the minimum.

Reset
REQ-028 While i_rstn=0: state GREEN, o_phase=0, timer=0, next-phase=0, hold NORMAL.
REQ-029 While i_rstn=0: o_light = way 0 G with all others R, and o_hold=0.
REQ-030 Reset assertion mid-cycle SHALL take effect immediately, without waiting for a clock edge, in any state.

Structure
REQ-031 Package traffic_pkg SHALL hold the light codes (L_R, L_G, L_Y), the main-state encodings and the hold-state encodings.
REQ-032 The round-robin candidate search SHALL be a combinational sub-module traffic_rr_pick, parameterised by N_WAY, with outputs valid and index.

Verification (defaults N_WAY=4, T_GMIN=5, T_GMAX=20, T_YEL=3, T_ALLRED=1)
REQ-033 Reset release with i_traff=0 -> o_light=8'b00_00_00_01, o_phase=0, o_hold=0; stays unchanged for 50 cycles.
REQ-034 i_traff=4'b0100 from reset -> way0 G 5 cycles, way0 Y 3 cycles, all-R 1 cycle, then o_light=8'b00_01_00_00 and o_phase=2.
REQ-035 i_traff=4'b0011 held -> way0 G exactly 20 cycles, then Y 3, all-R 1, then way1 G.
REQ-036 i_mode_p pulse at green cycle 2 with i_traff=4'b0010 -> o_hold=1 and way0 stays G for 100 cycles; i_mode_r pulse -> Y on the following cycle.
REQ-037 Phase 3 green with i_traff=4'b1001 and i_traff[3] dropped -> next green on way 0 (wrap-around); phase 1 skipped.
REQ-038 i_rstn low during YELLOW cycle 2 -> o_light=8'b00_00_00_01 immediately, before the next clock edge; normal sequence resumes after release.
